// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - I-cache fetch front end with {pc, inst} FIFO and redirect/flush
// Optional performance counters are enabled by defining FETCH_PERF_CTR_EN.
module fetch_redirect #(
    parameter logic [31:0] PC_RESET    = 32'h1ECE_B000,
    parameter int          QUEUE_DEPTH = 16,
    parameter int          PC_STEP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ufp_addr,
    output logic [3:0]  ufp_rmask,
    output logic [3:0]  ufp_wmask,
    output logic [31:0] ufp_wdata,
    input  logic [31:0] ufp_rdata,
    input  logic        ufp_resp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dequeue,
    output logic        is_empty,
    output logic [63:0] dequeue_rdata
`ifdef FETCH_PERF_CTR_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_discard_cnt
`endif
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     pend_pc_q, pend_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [63:0]     mem_q [QUEUE_DEPTH];

    logic            enq;
    logic            deq;
    logic            discard;
    logic [31:0]     redirect_pc_al;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

    assign enq     = (state_q == S_READ) && ufp_resp && !redirect_valid;
    assign deq     = dequeue && (count_q != '0) && !redirect_valid;
    // A response is stale if it lands in DRAIN or races a redirect in READ.
    assign discard = ufp_resp && ((state_q == S_DRAIN) ||
                                  ((state_q == S_READ) && redirect_valid));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        if (redirect_valid) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (((state_q == S_READ) || (state_q == S_DRAIN)) && !ufp_resp) begin
                // Request still outstanding: wait for its response before refetching.
                state_d   = S_DRAIN;
                pend_pc_d = redirect_pc_al;
            end else begin
                state_d = S_READ;
                pc_d    = redirect_pc_al;
            end
        end else begin
            if (enq) begin
                tail_d = tail_q + PW'(1);
            end
            if (deq) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);

            case (state_q)
                S_IDLE: begin
                    state_d = S_READ;
                end
                S_READ: begin
                    if (ufp_resp) begin
                        pc_d    = pc_q + 32'(PC_STEP);
                        state_d = (count_d == DEPTH_C) ? S_WAIT : S_READ;
                    end
                end
                S_WAIT: begin
                    if (count_d < DEPTH_C) begin
                        state_d = S_READ;
                    end
                end
                S_DRAIN: begin
                    if (ufp_resp) begin
                        pc_d    = pend_pc_q;
                        state_d = S_READ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            pend_pc_q <= PC_RESET;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_q] <= {ufp_addr, ufp_rdata};
        end
    end

    assign ufp_addr      = pc_q;
    assign ufp_rmask     = ((state_q == S_READ) || (state_q == S_DRAIN)) ? 4'hF : 4'h0;
    assign ufp_wmask     = 4'h0;
    assign ufp_wdata     = 32'h0;
    assign is_empty      = (count_q == '0);
    assign dequeue_rdata = mem_q[head_q];

`ifdef FETCH_PERF_CTR_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] discard_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q   <= '0;
            discard_cnt_q <= '0;
        end else begin
            if (enq) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (discard) begin
                discard_cnt_q <= discard_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt   = fetch_cnt_q;
    assign perf_discard_cnt = discard_cnt_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - scoreboard bench for fetch_redirect (FETCH_PERF_CTR_EN optional)
module tb_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ufp_addr;
    logic [3:0]  ufp_rmask;
    logic [3:0]  ufp_wmask;
    logic [31:0] ufp_wdata;
    logic [31:0] ufp_rdata;
    logic        ufp_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dequeue;
    logic        is_empty;
    logic [63:0] dequeue_rdata;

    logic [31:0] w_addr;
    logic [3:0]  w_rmask;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic        w_resp;
    logic        w_deq;
    logic        w_empty;
    logic [63:0] w_head;

`ifdef FETCH_PERF_CTR_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_discard_cnt;
    logic [31:0] w_perf_fetch;
    logic [31:0] w_perf_discard;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_req_q   [$];
    logic [63:0] exp_entry_q [$];

    always #5 clk = ~clk;

    fetch_redirect dut (
        .clk            (clk),
        .rst            (rst),
        .ufp_addr       (ufp_addr),
        .ufp_rmask      (ufp_rmask),
        .ufp_wmask      (ufp_wmask),
        .ufp_wdata      (ufp_wdata),
        .ufp_rdata      (ufp_rdata),
        .ufp_resp       (ufp_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dequeue        (dequeue),
        .is_empty       (is_empty),
        .dequeue_rdata  (dequeue_rdata)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_discard_cnt (perf_discard_cnt)
`endif
    );

    fetch_redirect #(
        .PC_RESET    (32'hFFFF_FFFC),
        .QUEUE_DEPTH (4)
    ) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .ufp_addr       (w_addr),
        .ufp_rmask      (w_rmask),
        .ufp_wmask      (w_wmask),
        .ufp_wdata      (w_wdata),
        .ufp_rdata      (w_rdata),
        .ufp_resp       (w_resp),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .dequeue        (w_deq),
        .is_empty       (w_empty),
        .dequeue_rdata  (w_head)
`ifdef FETCH_PERF_CTR_EN
        ,
        .perf_fetch_cnt   (w_perf_fetch),
        .perf_discard_cnt (w_perf_discard)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response checks the request address; every accepted pop checks the head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ufp_resp) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 64'(ufp_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("req_addr", 64'(ufp_addr), 64'(exp_req_q.pop_front()));
                    chk("req_rmask", 64'(ufp_rmask), 64'hF);
                end
            end
            if (dequeue && !is_empty) begin
                if (exp_entry_q.size() == 0) begin
                    chk("pop_unexpected", dequeue_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("pop_entry", dequeue_rdata, exp_entry_q.pop_front());
                end
            end
        end
    end

    task automatic respond(input logic [31:0] addr, input logic [31:0] data, input logic keep);
        ufp_resp  = 1'b1;
        ufp_rdata = data;
        exp_req_q.push_back(addr);
        if (keep) exp_entry_q.push_back({addr, data});
        tick();
        ufp_resp = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_req_q.delete();
        exp_entry_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ufp_rdata = '0; ufp_resp = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; dequeue = 1'b0; w_rdata = '0; w_resp = 1'b0; w_deq = 1'b0;
        tick();
        tick();
        chk("rst_rmask", 64'(ufp_rmask), 64'h0);
        chk("rst_addr", 64'(ufp_addr), 64'h1ECE_B000);
        chk("rst_empty", 64'(is_empty), 64'h1);
        chk("rst_wmask", 64'(ufp_wmask), 64'h0);
        chk("rst_wdata", 64'(ufp_wdata), 64'h0);

        // Fill: one response per cycle until full
        rst = 1'b0;
        chk("idle_rmask", 64'(ufp_rmask), 64'h0);
        tick();
        chk("first_req_rmask", 64'(ufp_rmask), 64'hF);
        for (int i = 0; i < 16; i++) begin
            respond(32'h1ECE_B000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1);
        end
        chk("full_rmask", 64'(ufp_rmask), 64'h0);
        chk("full_not_empty", 64'(is_empty), 64'h0);
        chk("full_head", dequeue_rdata, {32'h1ECE_B000, 32'hA000_0000});
        tick();
        chk("wait_holds", 64'(ufp_rmask), 64'h0);

        // Pop one from full queue: one more request issued
        dequeue = 1'b1;
        tick();
        dequeue = 1'b0;
        chk("refill_rmask", 64'(ufp_rmask), 64'hF);
        chk("refill_addr", 64'(ufp_addr), 64'h1ECE_B040);
        chk("head_after_pop", dequeue_rdata, {32'h1ECE_B004, 32'hA000_0001});
        respond(32'h1ECE_B040, 32'hA000_0010, 1'b1);
        chk("refull_rmask", 64'(ufp_rmask), 64'h0);
        dequeue = 1'b1;
        tick(); tick(); tick();
        dequeue = 1'b0;

        // Redirect while a request is outstanding -> DRAIN
        do_reset();
        tick();
        respond(32'h1ECE_B000, 32'hB000_0000, 1'b1);
        respond(32'h1ECE_B004, 32'hB000_0001, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0010;
        tick();
        redirect_valid = 1'b0;
        exp_entry_q.delete();
        chk("drain_empty", 64'(is_empty), 64'h1);
        chk("drain_rmask", 64'(ufp_rmask), 64'hF);
        chk("drain_addr", 64'(ufp_addr), 64'h1ECE_B008);
        tick(); tick();
        respond(32'h1ECE_B008, 32'hDEAD_BEEF, 1'b0);
        chk("stale_dropped", 64'(is_empty), 64'h1);
        chk("redir_addr", 64'(ufp_addr), 64'h8000_0010);
        respond(32'h8000_0010, 32'hC000_0000, 1'b1);
        chk("redir_entry_vis", 64'(is_empty), 64'h0);
`ifdef FETCH_PERF_CTR_EN
        chk("perf_fetch_drain", 64'(perf_fetch_cnt), 64'd3);
        chk("perf_discard_drain", 64'(perf_discard_cnt), 64'd1);
`endif
        dequeue = 1'b1;
        tick();
        dequeue = 1'b0;
        chk("redir_popped_empty", 64'(is_empty), 64'h1);

        // Redirect coincident with response and dequeue, unaligned target
        for (int i = 0; i < 5; i++) begin
            respond(32'h8000_0014 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0013;
        dequeue        = 1'b1;
        respond(32'h8000_0028, 32'hEEEE_EEEE, 1'b0);
        redirect_valid = 1'b0;
        dequeue        = 1'b0;
        exp_entry_q.delete();
        chk("coinc_empty", 64'(is_empty), 64'h1);
        chk("coinc_addr", 64'(ufp_addr), 64'h8000_0010);
        chk("coinc_rmask", 64'(ufp_rmask), 64'hF);
`ifdef FETCH_PERF_CTR_EN
        chk("perf_fetch_coinc", 64'(perf_fetch_cnt), 64'd8);
        chk("perf_discard_coinc", 64'(perf_discard_cnt), 64'd2);
`endif
        respond(32'h8000_0010, 32'hF000_0000, 1'b1);
        dequeue = 1'b1;
        tick();
        dequeue = 1'b0;

        // PC wrap on the second instance
        chk("wrap_addr0", 64'(w_addr), 64'hFFFF_FFFC);
        w_resp  = 1'b1;
        w_rdata = 32'h1111_1111;
        tick();
        chk("wrap_addr1", 64'(w_addr), 64'h0000_0000);
        w_rdata = 32'h2222_2222;
        tick();
        w_resp = 1'b0;
        chk("wrap_head0", w_head, {32'hFFFF_FFFC, 32'h1111_1111});
        w_deq = 1'b1;
        tick();
        w_deq = 1'b0;
        chk("wrap_head1", w_head, {32'h0000_0000, 32'h2222_2222});

        tick();
        chk("sb_req_left", 64'(exp_req_q.size()), 64'd0);
        chk("sb_entry_left", 64'(exp_entry_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
